// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clock_set_ctrl
//  Purpose  : Button-driven time-set controller. Captures the running time,
//             lets the user step hours then minutes, and issues a one-cycle
//             load strobe to the display counter. Abandons the edit on
//             cancel or after a period of button inactivity.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_cancel,
   input  logic [4:0] cur_hrs,
   input  logic [6:0] cur_min,
   output logic       set,
   output logic [4:0] set_hours,
   output logic [6:0] set_minutes,
   output logic       edit_active,
   output logic [1:0] edit_field
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_EDIT_HRS = 2'b01,
      S_EDIT_MIN = 2'b10,
      S_COMMIT   = 2'b11
   } state_t;

   // Last counter value before the edit is abandoned.
   localparam logic [31:0] c_TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

   state_t      r_state;
   logic [4:0]  r_edit_hrs;
   logic [6:0]  r_edit_min;
   logic [31:0] r_idle_cnt;
   logic        r_set;
   logic [4:0]  r_set_hours;
   logic [6:0]  r_set_minutes;

   logic [4:0]  w_cap_hrs;
   logic [6:0]  w_cap_min;
   logic [4:0]  w_hrs_next;
   logic [6:0]  w_min_next;
   logic        w_timeout;

   // Sanitised capture values and wrapping increments of the edit fields.
   always_comb begin
      w_cap_hrs  = (cur_hrs > 5'd23) ? 5'd0 : cur_hrs;
      w_cap_min  = (cur_min > 7'd59) ? 7'd0 : cur_min;
      w_hrs_next = (r_edit_hrs >= 5'd23) ? 5'd0 : r_edit_hrs + 5'd1;
      w_min_next = (r_edit_min >= 7'd59) ? 7'd0 : r_edit_min + 7'd1;
      w_timeout  = (r_idle_cnt == c_TIMEOUT_LAST);
   end

   // Edit FSM with registered strobe, load values and inactivity counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_edit_hrs    <= 5'd0;
         r_edit_min    <= 7'd0;
         r_idle_cnt    <= 32'd0;
         r_set         <= 1'b0;
         r_set_hours   <= 5'd0;
         r_set_minutes <= 7'd0;
      end else begin
         r_set <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_idle_cnt <= 32'd0;
               if (btn_mode) begin
                  r_edit_hrs <= w_cap_hrs;
                  r_edit_min <= w_cap_min;
                  r_state    <= S_EDIT_HRS;
               end
            end
            S_EDIT_HRS, S_EDIT_MIN: begin
               // cancel beats mode beats inc; only one action per cycle
               if (btn_cancel) begin
                  r_idle_cnt <= 32'd0;
                  r_state    <= S_IDLE;
               end else if (btn_mode) begin
                  r_idle_cnt <= 32'd0;
                  if (r_state == S_EDIT_HRS) begin
                     r_state <= S_EDIT_MIN;
                  end else begin
                     r_state       <= S_COMMIT;
                     r_set         <= 1'b1;
                     r_set_hours   <= r_edit_hrs;
                     r_set_minutes <= r_edit_min;
                  end
               end else if (btn_inc) begin
                  r_idle_cnt <= 32'd0;
                  if (r_state == S_EDIT_HRS) begin
                     r_edit_hrs <= w_hrs_next;
                  end else begin
                     r_edit_min <= w_min_next;
                  end
               end else if (w_timeout) begin
                  r_idle_cnt <= 32'd0;
                  r_state    <= S_IDLE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + 32'd1;
               end
            end
            S_COMMIT: begin
               r_idle_cnt <= 32'd0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_idle_cnt <= 32'd0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the registered state.
   always_comb begin
      edit_active = (r_state != S_IDLE);
      edit_field  = 2'b00;
      case (r_state)
         S_EDIT_HRS: edit_field = 2'b01;
         S_EDIT_MIN: edit_field = 2'b10;
         default:    edit_field = 2'b00;
      endcase
   end

   assign set         = r_set;
   assign set_hours   = r_set_hours;
   assign set_minutes = r_set_minutes;

endmodule
`default_nettype wire
